// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader and its neighbours
// (mother_board, cpu).
package prog_loader_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/prog_ram.sv
// Program RAM: one synchronous write port, one asynchronous read port.
module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; stale words are hidden by the loader's word count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Downloads a program over a valid/ready port into prog_ram, holds the CPU in
// reset while loading, then serves combinational instruction fetches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              addr_loaded;
  logic [DATA_W-1:0] ram_rdata;

  assign xfer = ld_valid && (state_q == ST_LOAD);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      wr_ptr_q   <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first so no path leaves a variable unassigned (no latches).
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
          word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
          if (ld_last) begin
            state_d = ST_RUN;
          end else if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            // Memory full without a last marker: run what we have and flag it.
            state_d    = ST_RUN;
            err_d      = 1'b1;
            word_cnt_d = (ADDR_W + 1)'(DEPTH);
          end
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = '0;
          word_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
    endcase
  end

  prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (wr_ptr_q),
    .wdata (ld_data),
    .raddr (cpu_addr),
    .rdata (ram_rdata)
  );

  // Locations beyond the current program read as zero, the CPU's NOP-like default.
  assign addr_loaded = ({1'b0, cpu_addr} < word_cnt_q);
  assign cpu_data    = (state_q == ST_RUN && addr_loaded) ? ram_rdata : '0;

  assign ld_ready  = (state_q == ST_LOAD);
  assign cpu_hold  = (state_q == ST_LOAD);
  assign load_done = (state_q == ST_RUN);
  assign word_cnt  = word_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected outputs, a negedge
// monitor pops and compares them.
module tb_prog_loader;

  logic       clk;
  logic       reset;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       reload;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_hold;
  logic       load_done;
  logic [4:0] word_cnt;
  logic       err;

  typedef struct packed {
    logic [7:0] data;
    logic       hold;
    logic [4:0] cnt;
    logic       err;
  } exp_t;

  exp_t  exp_q [$];
  string name_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .reload    (reload),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .word_cnt  (word_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: one queued expectation is compared per negedge, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, ".cpu_data"},  32'(cpu_data),  32'(e.data));
      check({nm, ".cpu_hold"},  32'(cpu_hold),  32'(e.hold));
      check({nm, ".ld_ready"},  32'(ld_ready),  32'(e.hold));
      check({nm, ".load_done"}, 32'(load_done), 32'(!e.hold));
      check({nm, ".word_cnt"},  32'(word_cnt),  32'(e.cnt));
      check({nm, ".err"},       32'(err),       32'(e.err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) begin
      ld_data = 8'($urandom);
      tick();
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] addr, input logic [7:0] data,
                            input logic hold, input logic [4:0] cnt, input logic e);
    cpu_addr = addr;
    name_q.push_back(nm);
    exp_q.push_back('{data: data, hold: hold, cnt: cnt, err: e});
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    reload   = 1'b0;
    cpu_addr = '0;
    tick();
    expect_out("reset", 4'd0, 8'h00, 1'b1, 5'd0, 1'b0);
    reset = 1'b0;
    tick();

    // Basic three-word load
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    expect_out("mid_load", 4'd1, 8'h00, 1'b1, 5'd2, 1'b0);
    send(8'h33, 1'b1);
    expect_out("load_a0", 4'd0, 8'h11, 1'b0, 5'd3, 1'b0);
    expect_out("load_a1", 4'd1, 8'h22, 1'b0, 5'd3, 1'b0);
    expect_out("load_a2", 4'd2, 8'h33, 1'b0, 5'd3, 1'b0);
    expect_out("load_a3", 4'd3, 8'h00, 1'b0, 5'd3, 1'b0);

    // Load attempt while running is ignored
    send(8'hFF, 1'b0);
    expect_out("run_ign_a0", 4'd0, 8'h11, 1'b0, 5'd3, 1'b0);
    expect_out("run_ign_a2", 4'd2, 8'h33, 1'b0, 5'd3, 1'b0);
    expect_out("run_ign_a3", 4'd3, 8'h00, 1'b0, 5'd3, 1'b0);

    // Reload, then a one-word program masks stale words
    pulse_reload();
    expect_out("reload", 4'd0, 8'h00, 1'b1, 5'd0, 1'b0);
    send(8'hA5, 1'b1);
    expect_out("reld_a0", 4'd0, 8'hA5, 1'b0, 5'd1, 1'b0);
    expect_out("reld_a1", 4'd1, 8'h00, 1'b0, 5'd1, 1'b0);

    // Gaps between handshakes
    pulse_reload();
    gap();
    send(8'h5A, 1'b0);
    gap();
    send(8'h6B, 1'b0);
    gap();
    send(8'h7C, 1'b1);
    gap();
    expect_out("gap_a0", 4'd0, 8'h5A, 1'b0, 5'd3, 1'b0);
    expect_out("gap_a1", 4'd1, 8'h6B, 1'b0, 5'd3, 1'b0);
    expect_out("gap_a2", 4'd2, 8'h7C, 1'b0, 5'd3, 1'b0);

    // Overflow: sixteen words with no last marker
    pulse_reload();
    for (int i = 0; i < 16; i++) begin
      send(8'h80 + 8'(i), 1'b0);
      if (i == 14) expect_out("ovf_pre", 4'd0, 8'h00, 1'b1, 5'd15, 1'b0);
    end
    expect_out("ovf_a15", 4'd15, 8'h8F, 1'b0, 5'd16, 1'b1);
    expect_out("ovf_a0",  4'd0,  8'h80, 1'b0, 5'd16, 1'b1);
    pulse_reload();
    expect_out("ovf_clr", 4'd15, 8'h00, 1'b1, 5'd0, 1'b0);

    // Asynchronous reset mid-load, asserted away from the clock edge
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    reset = 1'b1;
    expect_out("async_rst", 4'd1, 8'h00, 1'b1, 5'd0, 1'b0);
    reset = 1'b0;
    send(8'hD1, 1'b1);
    expect_out("post_rst_a0", 4'd0, 8'hD1, 1'b0, 5'd1, 1'b0);
    expect_out("post_rst_a1", 4'd1, 8'h00, 1'b0, 5'd1, 1'b0);

    // Reload during LOAD does not restart the pointer
    pulse_reload();
    send(8'hE1, 1'b0);
    pulse_reload();
    expect_out("ign_reload", 4'd0, 8'h00, 1'b1, 5'd1, 1'b0);
    send(8'hE2, 1'b1);
    expect_out("ign_rl_a0", 4'd0, 8'hE1, 1'b0, 5'd2, 1'b0);
    expect_out("ign_rl_a1", 4'd1, 8'hE2, 1'b0, 5'd2, 1'b0);
    expect_out("ign_rl_a2", 4'd2, 8'h00, 1'b0, 5'd2, 1'b0);

    repeat (3) tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
